mdr_buffered: RTL and testbench

Parametrised memory data register. Holds the last word read from memory for the internal tri-state bus, and buffers bus-to-memory writes in a small FIFO so the datapath never stalls on a slow memory write port. Sits between the shared datapath bus and the memory interface. It replaces the unbuffered, enable-clocked MDR with a single-clock design that has handshakes on both memory directions.

---
 rtl/mdr_pkg.sv | 18 +
 rtl/mdr_wbuf.sv | 88 ++++++++
 rtl/mdr_buffered.sv | 105 ++++++++++
 tb/tb_mdr_buffered.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared types and helpers for the buffered memory data register.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mdr_pkg;

    // Read sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        WAIT  = 2'd2
    } rd_state_t;

    // Width of a counter that must be able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mdr_wbuf.sv
// Circular write-buffer FIFO between the datapath bus and the memory write port.
// Latency: push at edge n is visible at the head from n+1; pop at edge n exposes the next entry from n+1.
// Backpressure: none upstream; a push into a full buffer without a pop is dropped and flags a sticky overflow.
module mdr_wbuf
    import mdr_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int CW     = cnt_w(DEPTH),
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_vld,
    input  logic [DATA_W-1:0] wr_dat,
    output logic              rd_vld,
    output logic [DATA_W-1:0] rd_dat,
    input  logic              rd_rdy,
    output logic              full,
    output logic [CW-1:0]     count,
    output logic              overflow
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt_q;
    logic              ovf_q;
    logic              push;
    logic              pop;

    // Status is decoded only from registered state so the memory side never
    // sees a combinational path from its own ready back into valid.
    assign full     = (cnt_q == CW'(DEPTH));
    assign rd_vld   = (cnt_q != '0);
    assign rd_dat   = mem[rd_ptr];
    assign count    = cnt_q;
    assign overflow = ovf_q;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign pop  = rd_vld && rd_rdy;
    assign push = wr_vld && (!full || pop);

    // Storage array: written on accepted push, no reset needed since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Sticky drop flag: only cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr_vld && full && !pop) begin
            ovf_q <= 1'b1;
        end
    end

endmodule

// File: rtl/mdr_buffered.sv
// Memory data register: holds the last memory read for the shared bus and buffers bus-to-memory writes.
// Latency: read takes >=2 cycles readReq-to-data; buffered write reaches memWrValid one cycle after writeEn.
// Backpressure: memWrReady stalls the write buffer; a read waits for the buffer to drain, then for memRdValid.
module mdr_buffered
    import mdr_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int WB_DEPTH = 4,
    localparam int CW       = cnt_w(WB_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              rOutEn,
    input  logic              writeEn,
    input  logic              readReq,
    output logic              memRdReq,
    input  logic [DATA_W-1:0] memRdData,
    input  logic              memRdValid,
    output logic [DATA_W-1:0] memWrData,
    output logic              memWrValid,
    input  logic              memWrReady,
    output logic              rdBusy,
    output logic              wbFull,
    output logic [CW-1:0]     wbCount,
    output logic              overflow
);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [DATA_W-1:0] saved_q;
    logic              load_saved;

    // The bus value is captured into the write buffer whenever writeEn is high;
    // the datapath never waits on the memory write port.
    mdr_wbuf #(
        .DATA_W (DATA_W),
        .DEPTH  (WB_DEPTH)
    ) u_wbuf (
        .clk      (clk),
        .reset    (reset),
        .wr_vld   (writeEn),
        .wr_dat   (bus),
        .rd_vld   (memWrValid),
        .rd_dat   (memWrData),
        .rd_rdy   (memWrReady),
        .full     (wbFull),
        .count    (wbCount),
        .overflow (overflow)
    );

    // Drive the shared bus only while the datapath asks for the saved word.
    assign bus = rOutEn ? saved_q : {DATA_W{1'bz}};

    // Read sequencing: a read is held back until earlier buffered writes have
    // left, so memory sees writes and reads in program order.
    always_comb begin
        state_d    = state_q;
        memRdReq   = 1'b0;
        load_saved = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (readReq) begin
                    state_d = (wbCount != '0) ? DRAIN : WAIT;
                end
            end
            DRAIN: begin
                if (wbCount == '0) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                memRdReq = 1'b1;
                if (memRdValid) begin
                    load_saved = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdBusy = (state_q != IDLE);

    // State register; reset abandons any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Saved read word; a response landing in the reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            saved_q <= '0;
        end else if (load_saved) begin
            saved_q <= memRdData;
        end
    end

endmodule

// File: tb/tb_mdr_buffered.sv
module tb_mdr_buffered;

    localparam int DATA_W   = 16;
    localparam int WB_DEPTH = 4;
    localparam int CW       = $clog2(WB_DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    wire  [DATA_W-1:0] bus;
    logic              rOutEn;
    logic              writeEn;
    logic              readReq;
    logic              memRdReq;
    logic [DATA_W-1:0] memRdData;
    logic              memRdValid;
    logic [DATA_W-1:0] memWrData;
    logic              memWrValid;
    logic              memWrReady;
    logic              rdBusy;
    logic              wbFull;
    logic [CW-1:0]     wbCount;
    logic              overflow;

    logic              tb_bus_en;
    logic [DATA_W-1:0] tb_bus_dat;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_wr[$];
    logic [DATA_W-1:0] exp_rd[$];

    assign bus = tb_bus_en ? tb_bus_dat : {DATA_W{1'bz}};

    always #5 clk = ~clk;

    mdr_buffered #(
        .DATA_W   (DATA_W),
        .WB_DEPTH (WB_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .rOutEn     (rOutEn),
        .writeEn    (writeEn),
        .readReq    (readReq),
        .memRdReq   (memRdReq),
        .memRdData  (memRdData),
        .memRdValid (memRdValid),
        .memWrData  (memWrData),
        .memWrValid (memWrValid),
        .memWrReady (memWrReady),
        .rdBusy     (rdBusy),
        .wbFull     (wbFull),
        .wbCount    (wbCount),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put val on the bus and push it into the write buffer for one edge.
    task automatic push(input logic [DATA_W-1:0] val);
        rOutEn     = 1'b0;
        tb_bus_en  = 1'b1;
        tb_bus_dat = val;
        writeEn    = 1'b1;
        tick();
        writeEn    = 1'b0;
        tb_bus_en  = 1'b0;
        rOutEn     = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Monitor: memory write transfers and read completions against the scoreboard.
    initial begin
        logic rdreq_prev;
        rdreq_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && memWrValid && memWrReady) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got %0h expected none", memWrData);
                end else begin
                    chk("wr_data", 32'(memWrData), 32'(exp_wr.pop_front()));
                end
            end
            if (rdreq_prev && !memRdReq && rOutEn) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %0h expected none", bus);
                end else begin
                    chk("rd_data", 32'(bus), 32'(exp_rd.pop_front()));
                end
            end
            rdreq_prev = memRdReq;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with writeEn and readReq active; the bench drives the bus.
        reset      = 1'b1;
        writeEn    = 1'b1;
        readReq    = 1'b1;
        memWrReady = 1'b0;
        memRdValid = 1'b0;
        memRdData  = '0;
        rOutEn     = 1'b0;
        tb_bus_en  = 1'b1;
        tb_bus_dat = 16'hA5A5;
        tick();
        tick();
        chk("rst_memRdReq",   32'(memRdReq),   0);
        chk("rst_memWrValid", 32'(memWrValid), 0);
        chk("rst_wbFull",     32'(wbFull),     0);
        chk("rst_wbCount",    32'(wbCount),    0);
        chk("rst_overflow",   32'(overflow),   0);
        chk("rst_rdBusy",     32'(rdBusy),     0);
        chk("rst_bus_release", 32'(bus), 32'h0000A5A5);
        writeEn   = 1'b0;
        readReq   = 1'b0;
        tb_bus_en = 1'b0;
        rOutEn    = 1'b1;
        #1;
        chk("rst_saved", 32'(bus), 0);
        reset = 1'b0;
        tick();

        // Read with an empty buffer, memory answers 3 cycles later.
        chk("rd0_idle_req", 32'(memRdReq), 0);
        readReq = 1'b1;
        tick();
        readReq = 1'b0;
        chk("rd0_req_c1", 32'(memRdReq), 1);
        chk("rd0_busy",   32'(rdBusy),   1);
        tick();
        chk("rd0_req_c2", 32'(memRdReq), 1);
        tick();
        chk("rd0_req_c3", 32'(memRdReq), 1);
        memRdValid = 1'b1;
        memRdData  = 16'hBEEF;
        exp_rd.push_back(16'hBEEF);
        tick();
        memRdValid = 1'b0;
        chk("rd0_req_low", 32'(memRdReq), 0);
        chk("rd0_idle",    32'(rdBusy),   0);
        chk("rd0_bus",     32'(bus),      32'h0000BEEF);
        tick();

        // Buffered writes must leave before the following read is issued.
        push(16'h0001); exp_wr.push_back(16'h0001);
        push(16'h0002); exp_wr.push_back(16'h0002);
        chk("ord_count", 32'(wbCount),    2);
        chk("ord_vld",   32'(memWrValid), 1);
        chk("ord_head",  32'(memWrData),  32'h00000001);
        readReq = 1'b1;
        tick();
        readReq = 1'b0;
        chk("ord_busy", 32'(rdBusy), 1);
        for (int i = 0; i < 4; i++) begin
            chk("ord_hold_req", 32'(memRdReq), 0);
            if (i < 3) tick();
        end
        memWrReady = 1'b1;
        tick();
        chk("ord_count1", 32'(wbCount),  1);
        chk("ord_req_d1", 32'(memRdReq), 0);
        tick();
        chk("ord_count0", 32'(wbCount),  0);
        chk("ord_req_d0", 32'(memRdReq), 0);
        memWrReady = 1'b0;
        tick();
        chk("ord_req_rise", 32'(memRdReq), 1);
        memRdValid = 1'b1;
        memRdData  = 16'h5A5A;
        exp_rd.push_back(16'h5A5A);
        tick();
        memRdValid = 1'b0;
        chk("ord_req_done", 32'(memRdReq), 0);
        tick();

        // Five pushes into a 4-deep buffer with memory stalled.
        push(16'h1111); exp_wr.push_back(16'h1111);
        push(16'h2222); exp_wr.push_back(16'h2222);
        push(16'h3333); exp_wr.push_back(16'h3333);
        push(16'h4444); exp_wr.push_back(16'h4444);
        chk("full_ovf_before", 32'(overflow), 0);
        push(16'h5555);
        chk("full_flag",  32'(wbFull),    1);
        chk("full_count", 32'(wbCount),   4);
        chk("full_ovf",   32'(overflow),  1);
        chk("full_head",  32'(memWrData), 32'h00001111);
        memWrReady = 1'b1;
        repeat (4) tick();
        memWrReady = 1'b0;
        chk("full_drained", 32'(wbCount),    0);
        chk("full_vld0",    32'(memWrValid), 0);
        chk("ovf_sticky",   32'(overflow),   1);
        do_reset();
        chk("ovf_cleared",  32'(overflow),   0);

        // Full buffer with push and pop together, long enough to wrap pointers.
        for (int i = 0; i < 4; i++) begin
            push(16'hA0 + 16'(i));
            exp_wr.push_back(16'hA0 + 16'(i));
        end
        for (int i = 0; i < 12; i++) begin
            rOutEn     = 1'b0;
            tb_bus_en  = 1'b1;
            tb_bus_dat = 16'hB0 + 16'(i);
            writeEn    = 1'b1;
            memWrReady = 1'b1;
            exp_wr.push_back(16'hB0 + 16'(i));
            tick();
            chk("pp_count", 32'(wbCount),  4);
            chk("pp_full",  32'(wbFull),   1);
            chk("pp_ovf",   32'(overflow), 0);
        end
        writeEn   = 1'b0;
        tb_bus_en = 1'b0;
        rOutEn    = 1'b1;
        repeat (3) tick();
        chk("pp_last_head", 32'(memWrData), 32'h000000BB);
        tick();
        memWrReady = 1'b0;
        chk("pp_empty", 32'(wbCount),    0);
        chk("pp_vld0",  32'(memWrValid), 0);

        // Reset during WAIT, with a response arriving in the reset cycle.
        readReq = 1'b1;
        tick();
        readReq = 1'b0;
        chk("mr_req", 32'(memRdReq), 1);
        tick();
        reset      = 1'b1;
        memRdValid = 1'b1;
        memRdData  = 16'h1234;
        exp_rd.push_back(16'h0000);
        tick();
        reset      = 1'b0;
        memRdValid = 1'b0;
        chk("mr_req_low", 32'(memRdReq), 0);
        chk("mr_idle",    32'(rdBusy),   0);
        chk("mr_saved",   32'(bus),      0);
        // A stray response while idle is ignored.
        memRdValid = 1'b1;
        memRdData  = 16'h7777;
        tick();
        memRdValid = 1'b0;
        chk("stray_rsp", 32'(bus), 0);
        tick();
        tick();

        chk("wr_queue_empty", 32'(exp_wr.size()), 0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
